// File: rtl/wisc_pkg.sv
// Shared constants and types for the write-back stage and register file.
package wisc_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned LINK_REG = 7;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_src_e;

endpackage : wisc_pkg

// File: rtl/wb_mux.sv
// Write-back source select plus detection of the illegal JAL+load combination.
module wb_mux
  import wisc_pkg::*;
(
  input  logic              i_mem_to_reg,
  input  logic              i_jal_en,
  input  logic [DATA_W-1:0] i_read_data,
  input  logic [DATA_W-1:0] i_result,
  input  logic [DATA_W-1:0] i_next_pc,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_illegal
);

  wb_src_e w_src;

  // Link has priority over load, which has priority over the ALU result.
  always_comb begin
    w_src = WB_ALU;
    if (i_jal_en) begin
      w_src = WB_LINK;
    end else if (i_mem_to_reg) begin
      w_src = WB_MEM;
    end
  end

  always_comb begin
    o_wb_data = i_result;
    case (w_src)
      WB_MEM:  o_wb_data = i_read_data;
      WB_LINK: o_wb_data = i_next_pc;
      default: o_wb_data = i_result;
    endcase
  end

  assign o_illegal = i_jal_en & i_mem_to_reg;

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// Write-back stage and 8x16 architectural register file with two bypassed read ports.
module wb_regfile
  import wisc_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              JALen,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] result,
  input  logic [SEL_W-1:0]  reg_wr_sel,
  input  logic [DATA_W-1:0] nextPC,
  input  logic [SEL_W-1:0]  rd_sel1,
  input  logic [SEL_W-1:0]  rd_sel2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err
);

  logic [DATA_W-1:0] r_gpr [NUM_REGS];
  logic              r_err;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_illegal;
  logic              w_wr_en;
  logic [SEL_W-1:0]  w_wr_sel;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  wb_mux u_wb_mux (
    .i_mem_to_reg (mem_to_reg),
    .i_jal_en     (JALen),
    .i_read_data  (read_data),
    .i_result     (result),
    .i_next_pc    (nextPC),
    .o_wb_data    (w_wb_data),
    .o_illegal    (w_illegal)
  );

  assign w_wr_en  = (reg_write | JALen) & ~w_illegal;
  assign w_wr_sel = JALen ? SEL_W'(LINK_REG) : reg_wr_sel;

  // Storage commit and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_gpr[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_gpr[w_wr_sel] <= w_wb_data;
      end
      if (w_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

  // Read ports: storage, overridden by the in-flight write, forced to zero in reset.
  always_comb begin
    w_rd1 = r_gpr[rd_sel1];
    w_rd2 = r_gpr[rd_sel2];
    if (BYPASS && w_wr_en && (w_wr_sel == rd_sel1)) begin
      w_rd1 = w_wb_data;
    end
    if (BYPASS && w_wr_en && (w_wr_sel == rd_sel2)) begin
      w_rd2 = w_wb_data;
    end
    if (!rst_n) begin
      w_rd1 = '0;
      w_rd2 = '0;
    end
  end

  assign rd_data1 = w_rd1;
  assign rd_data2 = w_rd2;
  assign wb_data  = w_wb_data;
  assign wb_err   = r_err;

endmodule : wb_regfile
